// File: rtl/pixel_pack_gen_pkg.sv
// pixel_pack_gen_pkg: lane-order constants and lane-keep mask helper shared by the pixel packer
package pixel_pack_gen_pkg;
    localparam int ORDER_LSB_FIRST = 0;
    localparam int ORDER_MSB_FIRST = 1;
    localparam int KEEP_W = 32;

    function automatic logic [KEEP_W-1:0] keep_mask(input int used, input int div, input int order);
        logic [KEEP_W-1:0] m;
        m = (KEEP_W'(1) << used) - KEEP_W'(1);
        return order == ORDER_MSB_FIRST ? m << (div - used) : m;
    endfunction
endpackage

// File: rtl/pixel_pack_gen_shift_reg.sv
// shift_reg: TAPE-stage delay line of D_WIDTH-bit words, cleared on reset
module shift_reg #(
    parameter int D_WIDTH = 2,
    parameter int TAPE = 1
) (
    input  logic               in_pclk,
    input  logic               in_rstn,
    input  logic [D_WIDTH-1:0] d,
    output logic [D_WIDTH-1:0] q
);
    logic [D_WIDTH-1:0] pipe [TAPE];

    always_ff @(posedge in_pclk or negedge in_rstn) begin
        if (!in_rstn) begin
            for (int i = 0; i < TAPE; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < TAPE; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[TAPE-1];
endmodule

// File: rtl/pixel_pack_gen.sv
// pixel_pack_gen: packs PACK_DIV pixels per word, flushes partial groups at DE fall,
// and regenerates word-domain x/y counters with delay-matched sync
module pixel_pack_gen
    import pixel_pack_gen_pkg::*;
#(
    parameter int PIXEL_BIT = 16,
    parameter int PACK_DIV = 4,
    parameter int X_WIDTH = 12,
    parameter int ORDER = 0,
    parameter int SYNC_POL = 1,
    localparam int PACK_BIT = PIXEL_BIT * PACK_DIV
) (
    input  logic                 in_pclk,
    input  logic                 in_rstn,
    input  logic                 in_valid,
    input  logic                 in_de,
    input  logic                 in_hs,
    input  logic                 in_vs,
    input  logic [PIXEL_BIT-1:0] in_data,
    output logic                 out_valid,
    output logic [PACK_BIT-1:0]  out_data,
    output logic [PACK_DIV-1:0]  out_keep,
    output logic                 out_last,
    output logic [X_WIDTH-1:0]   out_x,
    output logic [X_WIDTH-1:0]   out_y,
    output logic                 out_de,
    output logic                 out_hs,
    output logic                 out_vs
);
    localparam int CW = $clog2(PACK_DIV);

    logic [CW-1:0]       cnt;
    logic [CW-1:0]       lane;
    logic [PACK_BIT-1:0] acc;
    logic [PACK_BIT-1:0] acc_w;
    logic [X_WIDTH-1:0]  x_cnt;
    logic                de_q;
    logic                seen;
    logic                y_inc;
    logic                accept;
    logic                de_fall;
    logic                full;
    logic                flush;

    assign accept  = in_valid && in_de;
    assign de_fall = de_q && !in_de;
    assign full    = accept && cnt == CW'(PACK_DIV - 1);
    assign flush   = de_fall && cnt != '0;
    assign lane    = ORDER == ORDER_MSB_FIRST ? CW'(PACK_DIV - 1) - cnt : cnt;

    always_comb begin
        acc_w = acc;
        acc_w[int'(lane)*PIXEL_BIT +: PIXEL_BIT] = in_data;
    end

    // out_y advances one cycle after DE fall so the line's flush word still carries the old index
    always_ff @(posedge in_pclk or negedge in_rstn) begin
        if (!in_rstn) begin
            cnt       <= '0;
            acc       <= '0;
            x_cnt     <= '0;
            de_q      <= 1'b0;
            seen      <= 1'b0;
            y_inc     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_de    <= 1'b0;
        end else begin
            de_q      <= in_de;
            out_de    <= in_de || flush;
            out_valid <= full || flush;
            out_last  <= flush;
            y_inc     <= de_fall && seen;
            if (full || flush) begin
                out_data <= flush ? acc : acc_w;
                out_keep <= full ? '1 : PACK_DIV'(keep_mask(int'(cnt), PACK_DIV, ORDER));
                out_x    <= x_cnt;
            end
            if (accept) begin
                cnt  <= full ? '0 : cnt + 1'b1;
                acc  <= full ? '0 : acc_w;
                seen <= 1'b1;
            end
            if (de_fall) begin
                cnt   <= '0;
                acc   <= '0;
                seen  <= 1'b0;
                x_cnt <= '0;
            end else if (full) begin
                x_cnt <= x_cnt + 1'b1;
            end
            if (in_vs == 1'(SYNC_POL))
                out_y <= '0;
            else if (y_inc)
                out_y <= out_y + 1'b1;
        end
    end

    shift_reg #(.D_WIDTH(2), .TAPE(1)) u_sync_dly (
        .in_pclk(in_pclk),
        .in_rstn(in_rstn),
        .d      ({in_hs, in_vs}),
        .q      ({out_hs, out_vs})
    );
endmodule
